// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control unit: sequences fetch/decode/execute/memory/writeback
// for the shared datapath, holds the {N,Z,C,V} flags and stalls on mem_ready.
module multicycle_ctrl #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000,
  parameter bit         MEM_WAIT_EN = 1'b1
) (
  input  logic        clkFPGA,
  input  logic        rst,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  ResultSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUControl,
  output logic [3:0]  Flags,
  output logic [3:0]  state_dbg,
  output logic        instr_done,
  output logic        illegal
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  state_t      state, next_state;
  logic [3:0]  flags_q;
  logic        cond_q;

  // Instruction fields
  logic [3:0]  cond;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic [3:0]  cmd;
  logic [3:0]  rd;
  logic        i_bit, s_bit, l_bit, rd_is_pc;
  logic        unused_instr_bits;

  assign cond     = Instr[31:28];
  assign op       = Instr[27:26];
  assign funct    = Instr[25:20];
  assign rd       = Instr[15:12];
  assign i_bit    = funct[5];
  assign cmd      = funct[4:1];
  assign s_bit    = funct[0];
  assign l_bit    = funct[0];
  assign rd_is_pc = (rd == 4'd15);
  assign unused_instr_bits = ^{Instr[19:16], Instr[11:0]};

  logic mem_rdy;
  assign mem_rdy = MEM_WAIT_EN ? mem_ready : 1'b1;

  // Data-processing command decode
  logic [1:0] cmd_alu;
  logic       cmd_legal, cmd_nowrite, cmd_arith, cmd_s;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    cmd_alu     = ALU_ADD;
    cmd_legal   = 1'b1;
    cmd_nowrite = 1'b0;
    cmd_arith   = 1'b0;
    cmd_s       = s_bit;
    case (cmd)
      4'b0100: cmd_arith = 1'b1;
      4'b0010: begin cmd_alu = ALU_SUB; cmd_arith = 1'b1; end
      4'b0000: cmd_alu = ALU_AND;
      4'b1100: cmd_alu = ALU_ORR;
      4'b1010: begin
        cmd_alu     = ALU_SUB;
        cmd_arith   = 1'b1;
        cmd_s       = 1'b1;
        cmd_nowrite = 1'b1;
      end
      default: begin
        cmd_legal   = 1'b0;
        cmd_nowrite = 1'b1;
      end
    endcase
  end

  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'b0000: cond_eval = z;
      4'b0001: cond_eval = ~z;
      4'b0010: cond_eval = cy;
      4'b0011: cond_eval = ~cy;
      4'b0100: cond_eval = n;
      4'b0101: cond_eval = ~n;
      4'b0110: cond_eval = v;
      4'b0111: cond_eval = ~v;
      4'b1000: cond_eval = cy & ~z;
      4'b1001: cond_eval = ~cy | z;
      4'b1010: cond_eval = (n == v);
      4'b1011: cond_eval = (n != v);
      4'b1100: cond_eval = ~z & (n == v);
      4'b1101: cond_eval = z | (n != v);
      4'b1110: cond_eval = 1'b1;
      default: cond_eval = 1'b0;
    endcase
  endfunction

  logic in_execute;
  assign in_execute = (state == S_EXECR) || (state == S_EXECI);

  always_ff @(posedge clkFPGA or negedge rst) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      state <= S_FETCH;
    end else begin
      state <= next_state;
    end
  end

  // cond_q is taken in DECODE, so an EXECUTE flag update cannot change the
  // predicate of its own writeback.
  always_ff @(posedge clkFPGA or negedge rst) begin
    if (!rst) begin
      flags_q <= RESET_FLAGS;
      cond_q  <= 1'b0;
    end else begin
      if (state == S_DECODE) cond_q <= cond_eval(cond, flags_q);
      if (in_execute && cond_q && cmd_s && cmd_legal) begin
        flags_q[3:2] <= ALUFlags[3:2];
        if (cmd_arith) flags_q[1:0] <= ALUFlags[1:0];
      end
    end
  end

  logic       pc_write, mem_write, ir_write, reg_write, done, illegal_raw;
  logic       adr_src, alu_src_a;
  logic [1:0] result_src, alu_src_b, alu_control;

  always_comb begin
    next_state  = state;
    pc_write    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    done        = 1'b0;
    illegal_raw = 1'b0;
    adr_src     = 1'b0;
    alu_src_a   = 1'b0;
    result_src  = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = ALU_ADD;
    case (state)
      S_FETCH: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_rdy;
        pc_write   = mem_rdy;
        if (mem_rdy) next_state = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        case (op)
          2'b00: begin
            next_state  = i_bit ? S_EXECI : S_EXECR;
            illegal_raw = ~cmd_legal;
          end
          2'b01:   next_state = S_MEMADR;
          2'b10:   next_state = S_BRANCH;
          default: begin
            illegal_raw = 1'b1;
            next_state  = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_b  = 2'b01;
        next_state = l_bit ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_rdy) next_state = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = cond_q;
        pc_write   = cond_q & rd_is_pc;
        done       = 1'b1;
        next_state = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = cond_q;
        // A squashed store does not wait for the memory handshake.
        if (mem_rdy || !cond_q) begin
          done       = 1'b1;
          next_state = S_FETCH;
        end
      end
      S_EXECR, S_EXECI: begin
        alu_src_b   = (state == S_EXECI) ? 2'b01 : 2'b00;
        alu_control = cmd_alu;
        next_state  = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = cond_q & ~cmd_nowrite;
        pc_write   = cond_q & ~cmd_nowrite & rd_is_pc;
        done       = 1'b1;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_write   = cond_q;
        done       = 1'b1;
        next_state = S_FETCH;
      end
      default: next_state = S_FETCH;
    endcase
  end

  // Enables and pulses are gated by the raw reset so they drop immediately.
  assign PCWrite    = pc_write  & rst;
  assign MemWrite   = mem_write & rst;
  assign IRWrite    = ir_write  & rst;
  assign RegWrite   = reg_write & rst;
  assign instr_done = done      & rst;
  assign illegal    = illegal_raw & rst;

  assign AdrSrc     = adr_src;
  assign ALUSrcA    = alu_src_a;
  assign ALUSrcB    = alu_src_b;
  assign ResultSrc  = result_src;
  assign ALUControl = alu_control;
  assign ImmSrc     = op;
  assign RegSrc     = {(op == 2'b01) & ~l_bit, (op == 2'b10)};
  assign Flags      = flags_q;
  assign state_dbg  = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle vector table for the main
// instruction classes plus hand sequences for memory stalls and reset.
module tb_multicycle_ctrl;

  logic        clkFPGA = 1'b0;
  logic        rst;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        mem_ready;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
  logic        instr_done, illegal;
  logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl;
  logic [3:0]  Flags, state_dbg;

  int checks = 0;
  int errors = 0;

  multicycle_ctrl #(.RESET_FLAGS(4'b0000), .MEM_WAIT_EN(1'b1)) dut (
    .clkFPGA(clkFPGA), .rst(rst), .Instr(Instr), .ALUFlags(ALUFlags),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
    .Flags(Flags), .state_dbg(state_dbg), .instr_done(instr_done),
    .illegal(illegal)
  );

  always #5 clkFPGA = ~clkFPGA;

  localparam logic [31:0] I_ADD   = 32'hE0821003;
  localparam logic [31:0] I_LDR   = 32'hE5921004;
  localparam logic [31:0] I_STR   = 32'hE5821004;
  localparam logic [31:0] I_STREQ = 32'h05821004;
  localparam logic [31:0] I_SUBS  = 32'hE0500000;
  localparam logic [31:0] I_BEQ   = 32'h0A000002;
  localparam logic [31:0] I_BNE   = 32'h1A000002;
  localparam logic [31:0] I_ORRS  = 32'hE1900000;
  localparam logic [31:0] I_ILL   = 32'hEC000000;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  alu_flags;
    logic        ready;
    logic [3:0]  st;
    logic        pcw, irw, mw, rw, adr;
    logic [1:0]  res, alu;
    logic        done, ill;
    logic [3:0]  flags;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic [31:0] instr, input logic [3:0] af,
                              input logic rdy, input logic [3:0] st,
                              input logic pcw, irw, mw, rw, adr,
                              input logic [1:0] res, alu,
                              input logic done, ill, input logic [3:0] fl);
    vec_t v;
    v.instr = instr; v.alu_flags = af; v.ready = rdy; v.st = st;
    v.pcw = pcw; v.irw = irw; v.mw = mw; v.rw = rw; v.adr = adr;
    v.res = res; v.alu = alu; v.done = done; v.ill = ill; v.flags = fl;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, settle, then sample.
  task automatic step(input logic [31:0] instr, input logic [3:0] af,
                      input logic rdy);
    @(negedge clkFPGA);
    Instr = instr; ALUFlags = af; mem_ready = rdy;
    #1;
  endtask

  int mw_cycles;
  int done_cycles;

  initial begin
    //              instr    af    rdy st  pcw irw mw rw adr res  alu  dn il flags
    vecs[0]  = mk(I_ADD,   4'h0, 0, 0,  0,  0,  0, 0, 0, 2'd2, 2'd0, 0, 0, 4'h0);
    vecs[1]  = mk(I_ADD,   4'h0, 1, 0,  1,  1,  0, 0, 0, 2'd2, 2'd0, 0, 0, 4'h0);
    vecs[2]  = mk(I_ADD,   4'h0, 1, 1,  0,  0,  0, 0, 0, 2'd2, 2'd0, 0, 0, 4'h0);
    vecs[3]  = mk(I_ADD,   4'hF, 1, 6,  0,  0,  0, 0, 0, 2'd0, 2'd0, 0, 0, 4'h0);
    vecs[4]  = mk(I_ADD,   4'hF, 1, 8,  0,  0,  0, 1, 0, 2'd0, 2'd0, 1, 0, 4'h0);
    vecs[5]  = mk(I_LDR,   4'h0, 1, 0,  1,  1,  0, 0, 0, 2'd2, 2'd0, 0, 0, 4'h0);
    vecs[6]  = mk(I_LDR,   4'h0, 1, 1,  0,  0,  0, 0, 0, 2'd2, 2'd0, 0, 0, 4'h0);
    vecs[7]  = mk(I_LDR,   4'h0, 1, 2,  0,  0,  0, 0, 0, 2'd0, 2'd0, 0, 0, 4'h0);
    vecs[8]  = mk(I_LDR,   4'h0, 1, 3,  0,  0,  0, 0, 1, 2'd0, 2'd0, 0, 0, 4'h0);
    vecs[9]  = mk(I_LDR,   4'h0, 1, 4,  0,  0,  0, 1, 0, 2'd1, 2'd0, 1, 0, 4'h0);
    vecs[10] = mk(I_SUBS,  4'h4, 1, 0,  1,  1,  0, 0, 0, 2'd2, 2'd0, 0, 0, 4'h0);
    vecs[11] = mk(I_SUBS,  4'h4, 1, 1,  0,  0,  0, 0, 0, 2'd2, 2'd0, 0, 0, 4'h0);
    vecs[12] = mk(I_SUBS,  4'h4, 1, 6,  0,  0,  0, 0, 0, 2'd0, 2'd1, 0, 0, 4'h0);
    vecs[13] = mk(I_SUBS,  4'h4, 1, 8,  0,  0,  0, 1, 0, 2'd0, 2'd0, 1, 0, 4'h4);
    vecs[14] = mk(I_BEQ,   4'h0, 1, 0,  1,  1,  0, 0, 0, 2'd2, 2'd0, 0, 0, 4'h4);
    vecs[15] = mk(I_BEQ,   4'h0, 1, 1,  0,  0,  0, 0, 0, 2'd2, 2'd0, 0, 0, 4'h4);
    vecs[16] = mk(I_BEQ,   4'h0, 1, 9,  1,  0,  0, 0, 0, 2'd2, 2'd0, 1, 0, 4'h4);
    vecs[17] = mk(I_BNE,   4'h0, 1, 0,  1,  1,  0, 0, 0, 2'd2, 2'd0, 0, 0, 4'h4);
    vecs[18] = mk(I_BNE,   4'h0, 1, 1,  0,  0,  0, 0, 0, 2'd2, 2'd0, 0, 0, 4'h4);
    vecs[19] = mk(I_BNE,   4'h0, 1, 9,  0,  0,  0, 0, 0, 2'd2, 2'd0, 1, 0, 4'h4);
    // ORRS: N,Z from ALU, C,V must hold their old values (0,0)
    vecs[20] = mk(I_ORRS,  4'hB, 1, 0,  1,  1,  0, 0, 0, 2'd2, 2'd0, 0, 0, 4'h4);
    vecs[21] = mk(I_ORRS,  4'hB, 1, 1,  0,  0,  0, 0, 0, 2'd2, 2'd0, 0, 0, 4'h4);
    vecs[22] = mk(I_ORRS,  4'hB, 1, 6,  0,  0,  0, 0, 0, 2'd0, 2'd3, 0, 0, 4'h4);
    vecs[23] = mk(I_ORRS,  4'hB, 1, 8,  0,  0,  0, 1, 0, 2'd0, 2'd0, 1, 0, 4'h8);
    vecs[24] = mk(I_ILL,   4'hF, 1, 0,  1,  1,  0, 0, 0, 2'd2, 2'd0, 0, 0, 4'h8);
    vecs[25] = mk(I_ILL,   4'hF, 1, 1,  0,  0,  0, 0, 0, 2'd2, 2'd0, 0, 1, 4'h8);
    vecs[26] = mk(I_ILL,   4'hF, 0, 0,  0,  0,  0, 0, 0, 2'd2, 2'd0, 0, 0, 4'h8);

    // Reset with mem_ready high: enables must still be held low.
    rst = 1'b0; Instr = I_ADD; ALUFlags = 4'h0; mem_ready = 1'b1;
    repeat (2) @(negedge clkFPGA);
    #1;
    check("rst state", 32'(state_dbg), 32'd0);
    check("rst PCWrite", 32'(PCWrite), 32'd0);
    check("rst IRWrite", 32'(IRWrite), 32'd0);
    check("rst Flags", 32'(Flags), 32'h0);
    @(negedge clkFPGA);
    mem_ready = 1'b0; rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].instr, vecs[i].alu_flags, vecs[i].ready);
      check($sformatf("v%0d state", i), 32'(state_dbg), 32'(vecs[i].st));
      check($sformatf("v%0d PCWrite", i), 32'(PCWrite), 32'(vecs[i].pcw));
      check($sformatf("v%0d IRWrite", i), 32'(IRWrite), 32'(vecs[i].irw));
      check($sformatf("v%0d MemWrite", i), 32'(MemWrite), 32'(vecs[i].mw));
      check($sformatf("v%0d RegWrite", i), 32'(RegWrite), 32'(vecs[i].rw));
      check($sformatf("v%0d AdrSrc", i), 32'(AdrSrc), 32'(vecs[i].adr));
      check($sformatf("v%0d ResultSrc", i), 32'(ResultSrc), 32'(vecs[i].res));
      check($sformatf("v%0d ALUControl", i), 32'(ALUControl), 32'(vecs[i].alu));
      check($sformatf("v%0d instr_done", i), 32'(instr_done), 32'(vecs[i].done));
      check($sformatf("v%0d illegal", i), 32'(illegal), 32'(vecs[i].ill));
      check($sformatf("v%0d Flags", i), 32'(Flags), 32'(vecs[i].flags));
    end

    // STR with memory stalled 3 cycles: MemWrite high for exactly 4 cycles.
    mw_cycles = 0; done_cycles = 0;
    step(I_STR, 4'h0, 1'b1);
    mw_cycles += int'(MemWrite); done_cycles += int'(instr_done);
    step(I_STR, 4'h0, 1'b1);
    check("str RegSrc", 32'(RegSrc), 32'h2);
    mw_cycles += int'(MemWrite); done_cycles += int'(instr_done);
    step(I_STR, 4'h0, 1'b1);
    check("str memadr state", 32'(state_dbg), 32'd2);
    mw_cycles += int'(MemWrite); done_cycles += int'(instr_done);
    for (int k = 0; k < 3; k++) begin
      step(I_STR, 4'h0, 1'b0);
      check($sformatf("str stall%0d state", k), 32'(state_dbg), 32'd5);
      mw_cycles += int'(MemWrite); done_cycles += int'(instr_done);
    end
    step(I_STR, 4'h0, 1'b1);
    check("str last done", 32'(instr_done), 32'd1);
    mw_cycles += int'(MemWrite); done_cycles += int'(instr_done);
    step(I_STR, 4'h0, 1'b0);
    check("str back to fetch", 32'(state_dbg), 32'd0);
    mw_cycles += int'(MemWrite); done_cycles += int'(instr_done);
    check("str MemWrite cycles", 32'(mw_cycles), 32'd4);
    check("str done pulses", 32'(done_cycles), 32'd1);

    // Asynchronous reset in the middle of a stalled store.
    step(I_STR, 4'h0, 1'b1);
    step(I_STR, 4'h0, 1'b1);
    step(I_STR, 4'h0, 1'b1);
    step(I_STR, 4'h0, 1'b0);
    check("arst pre MemWrite", 32'(MemWrite), 32'd1);
    check("arst pre Flags", 32'(Flags), 32'h8);
    #1 rst = 1'b0;
    #1;
    check("arst MemWrite", 32'(MemWrite), 32'd0);
    check("arst state", 32'(state_dbg), 32'd0);
    check("arst Flags", 32'(Flags), 32'h0);
    @(negedge clkFPGA);
    mem_ready = 1'b0; rst = 1'b1;

    // STREQ with Z=0: squashed store leaves MEMWRITE without waiting.
    step(I_STREQ, 4'h0, 1'b1);
    step(I_STREQ, 4'h0, 1'b1);
    step(I_STREQ, 4'h0, 1'b1);
    step(I_STREQ, 4'h0, 1'b0);
    check("streq state", 32'(state_dbg), 32'd5);
    check("streq MemWrite", 32'(MemWrite), 32'd0);
    check("streq done", 32'(instr_done), 32'd1);
    step(I_STREQ, 4'h0, 1'b0);
    check("streq to fetch", 32'(state_dbg), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multicycle control unit that sequences the shared CPU datapath (ALU, register file, memory port, PC) one instruction at a time. It replaces single-cycle combinational decode with a state machine. It generates per-cycle select and enable signals, holds the condition flags, and stalls on a memory-ready handshake. It sits between the instruction register and the datapath muxes and enables in the cpu top level.

Parameters:
RESET_FLAGS, 4'b0000, reset value of the flags register {N,Z,C,V}
MEM_WAIT_EN, 1, 1 = FETCH/MEMREAD/MEMWRITE wait for mem_ready; 0 = mem_ready ignored (single-cycle memory)

Ports:
clkFPGA  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
Instr  in  32  instruction register contents: Cond[31:28], Op[27:26], Funct[25:20], Rd[15:12]
ALUFlags  in  4  ALU {N,Z,C,V} for the current cycle
mem_ready  in  1  memory completes the access this cycle
PCWrite  out  1  PC register enable
AdrSrc  out  1  memory address select: 0 = PC, 1 = ALU result register
MemWrite  out  1  data memory write enable
IRWrite  out  1  instruction register enable
RegWrite  out  1  register file write enable
ResultSrc  out  2  00 ALUOut reg, 01 memory data, 10 ALU direct
ALUSrcA  out  1  0 = RD1, 1 = PC
ALUSrcB  out  2  00 RD2, 01 ExtImm, 10 constant 4
ImmSrc  out  2  = Op
RegSrc  out  2  [0] = branch (RA1 = R15), [1] = store (RA2 = Rd)
ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
Flags  out  4  registered {N,Z,C,V}
state_dbg  out  4  current state encoding
instr_done  out  1  one-cycle pulse on the last cycle of each instruction
illegal  out  1  one-cycle pulse in DECODE on an unsupported opcode or cmd

Behaviour:
- Reset (rst=0, asynchronous): state=FETCH(0), Flags=RESET_FLAGS, cond_q=0. While rst=0, every enable (PCWrite, IRWrite, MemWrite, RegWrite) is forced to 0, and instr_done=0, illegal=0. The first FETCH begins on the first rising edge after rst=1.
- Outputs are decoded combinationally from the state. Selects not listed for a state are 00/0.
- States:
  - FETCH(0): AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=00, ResultSrc=10. IRWrite=PCWrite=mem_ready. Stays in FETCH until mem_ready, then goes to DECODE.
  - DECODE(1): ALUSrcA=1, ALUSrcB=10, ResultSrc=10. Latches cond_q from Cond and Flags. Next state by Op: 00 goes to EXECUTER if I=0, else EXECUTEI; 01 goes to MEMADR; 10 goes to BRANCH; 11 raises illegal and goes to FETCH.
  - MEMADR(2): ALUSrcA=0, ALUSrcB=01, ADD. Goes to MEMREAD if L=Funct[0]=1, else MEMWRITE.
  - MEMREAD(3): AdrSrc=1. Goes to MEMWB when mem_ready.
  - MEMWB(4): ResultSrc=01, RegWrite=cond_q, PCWrite=cond_q&(Rd==15), instr_done=1. Goes to FETCH.
  - MEMWRITE(5): AdrSrc=1, MemWrite=cond_q, held until mem_ready, then goes to FETCH with instr_done=1. If cond_q=0, goes to FETCH in one cycle with MemWrite=0.
  - EXECUTER(6)/EXECUTEI(7): ALUSrcA=0, ALUSrcB=00 or 01, ALUControl from cmd. Flags updated at the end of the cycle if cond_q&S: N,Z always; C,V only for ADD/SUB/CMP. Goes to ALUWB.
  - ALUWB(8): ResultSrc=00, RegWrite=cond_q&~nowrite, PCWrite=RegWrite&(Rd==15), instr_done=1. Goes to FETCH.
  - BRANCH(9): ALUSrcA=0, ALUSrcB=01, ResultSrc=10, PCWrite=cond_q, instr_done=1. Goes to FETCH.
- cmd decode: 0100 ADD; 0010 SUB; 0000 AND; 1100 ORR; 1010 CMP (SUB, S forced to 1, nowrite=1). Any other cmd raises illegal in DECODE, selects ADD, sets nowrite=1, and updates no flags.
- Conditions: EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1; 1111 gives 0.
- Because cond_q is latched in DECODE, a flag update in EXECUTE does not affect the same instruction's writeback.
- With MEM_WAIT_EN=0, mem_ready is treated as 1.

Test Plan:
- Reset, then ADD R1,R2,R3 (0xE0821003), mem_ready=1 -> states 0,1,6,8,0. ALUControl=00 in state 6. RegWrite=1 only in state 8. instr_done pulses once. Flags stay 0000.
- LDR R1,[R2,#4] (0xE5921004) -> states 0,1,2,3,4 (5 cycles). AdrSrc=1 in state 3. ResultSrc=01 and RegWrite=1 in state 4.
- STR R1,[R2,#4] (0xE5821004) with mem_ready held low 3 cycles in MEMWRITE -> MemWrite=1 for exactly 4 cycles. Return to FETCH after mem_ready rises.
- SUBS R0,R0,R0 (0xE0500000) with ALUFlags=0100 -> Flags=0100. Then BEQ (0x0A000002) asserts PCWrite in BRANCH; BNE (0x1A000002) does not.
- rst driven low during MEMWRITE -> MemWrite falls to 0 in the same cycle without waiting for a clock edge. state_dbg=0 and Flags=0000.
- Op=11 (0xEC000000) -> states 0,1,0. illegal pulses in DECODE. No RegWrite, MemWrite or flag change.
